// File: rtl/store_write_port.sv
// Store buffer and data-memory write port: queues core stores, lane-steers them, drains over req/ack.
// Latency: a push into an empty buffer raises mem_req two edges later; back-to-back writes have no bubble.
// Backpressure: store_ready drops while the buffer holds DEPTH entries; optional macro STORE_TIMEOUT_EN abandons stuck writes.
module store_write_port #(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [31:0]                store_addr,
  input  logic [31:0]                store_val,
  input  logic [1:0]                 store_size,
  input  logic                       store_valid,
  output logic                       store_ready,
  output logic [31:0]                mem_addr,
  output logic [31:0]                mem_wdata,
  output logic [3:0]                 mem_wstrb,
  output logic                       mem_req,
  input  logic                       mem_ack,
  input  logic                       mem_err,
  output logic                       buffer_empty,
  output logic [$clog2(DEPTH+1)-1:0] buffer_count,
  output logic                       store_fault,
  output logic [31:0]                store_fault_addr
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     ent_addr_q  [DEPTH];
  logic [31:0]     ent_addr_d  [DEPTH];
  logic [31:0]     ent_wdata_q [DEPTH];
  logic [31:0]     ent_wdata_d [DEPTH];
  logic [3:0]      ent_wstrb_q [DEPTH];
  logic [3:0]      ent_wstrb_d [DEPTH];
  logic            fault_q, fault_d;
  logic [31:0]     fault_addr_q, fault_addr_d;

  logic            push, pop, rsv_fault, bus_fault, to_fault;
  logic [31:0]     new_wdata;
  logic [3:0]      new_wstrb;
  logic [31:0]     head_addr;

  assign head_addr = ent_addr_q[rd_ptr_q];

  // Lane steering of the incoming request, captured into the entry at push time
  always_comb begin
    new_wstrb = 4'b1111;
    new_wdata = store_val;
    case (store_size)
      2'b00: begin
        new_wstrb = 4'b0001 << store_addr[1:0];
        new_wdata = {4{store_val[7:0]}};
      end
      2'b01: begin
        new_wstrb = store_addr[1] ? 4'b1100 : 4'b0011;
        new_wdata = {2{store_val[15:0]}};
      end
      default: begin
        new_wstrb = 4'b1111;
        new_wdata = store_val;
      end
    endcase
  end

`ifdef STORE_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES+1) : 8;
  logic [TW-1:0] wait_q, wait_d;

  // Wait counter: restarts outside REQ (so it is zero on REQ entry) and on every pop
  always_comb begin
    to_fault = (state_q == REQ) && !mem_ack && (wait_q == TW'(TIMEOUT_CYCLES-1));
    wait_d   = wait_q + TW'(1);
    if (state_q != REQ || mem_ack || to_fault) wait_d = '0;
  end

  // Wait counter register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) wait_q <= '0;
    else          wait_q <= wait_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign to_fault       = 1'b0;
`endif

  // Buffer bookkeeping: push/pop decode, pointers, count and fault capture
  always_comb begin
    push      = store_valid && store_ready && (store_size != 2'b11);
    rsv_fault = store_valid && (store_size == 2'b11);
    bus_fault = (state_q == REQ) && mem_ack && mem_err;
    pop       = (state_q == REQ) && (mem_ack || to_fault);

    ent_addr_d  = ent_addr_q;
    ent_wdata_d = ent_wdata_q;
    ent_wstrb_d = ent_wstrb_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;

    if (push) begin
      ent_addr_d[wr_ptr_q]  = store_addr;
      ent_wdata_d[wr_ptr_q] = new_wdata;
      ent_wstrb_d[wr_ptr_q] = new_wstrb;
      wr_ptr_d              = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);

    // One fault source per cycle; a bus-side fault owns the address over a dropped reserved-size request
    fault_d      = bus_fault || to_fault || rsv_fault;
    fault_addr_d = fault_addr_q;
    if (bus_fault || to_fault) fault_addr_d = head_addr;
    else if (rsv_fault)        fault_addr_d = store_addr;
  end

  // Next-state logic: a timeout drops to IDLE for one cycle, an acked pop continues if work remains
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (count_q != '0) state_d = REQ;
      REQ: begin
        if (to_fault)                  state_d = IDLE;
        else if (pop && count_d == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, pointer, entry and fault registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_addr_q[i]  <= '0;
        ent_wdata_q[i] <= '0;
        ent_wstrb_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
      ent_addr_q   <= ent_addr_d;
      ent_wdata_q  <= ent_wdata_d;
      ent_wstrb_q  <= ent_wstrb_d;
    end
  end

  // Bus outputs come from the head entry only while requesting, so idle bus lines stay zero
  always_comb begin
    mem_req      = (state_q == REQ);
    mem_addr     = mem_req ? {head_addr[31:2], 2'b00} : 32'h0;
    mem_wdata    = mem_req ? ent_wdata_q[rd_ptr_q] : 32'h0;
    mem_wstrb    = mem_req ? ent_wstrb_q[rd_ptr_q] : 4'h0;
    store_ready  = (count_q < DEPTH_C);
    buffer_empty = (count_q == '0);
    buffer_count = count_q;
    store_fault      = fault_q;
    store_fault_addr = fault_addr_q;
  end

endmodule

// File: tb/tb_store_write_port.sv
// Directed bench for store_write_port with a write scoreboard and a fault-address queue.
// Expected bus writes and faults are queued at drive time and popped as the DUT produces them.
// Define STORE_TIMEOUT_EN for both files to run the timeout scenario as well.
module tb_store_write_port;

  logic        clk;
  logic        reset_n;
  logic [31:0] store_addr, store_val;
  logic [1:0]  store_size;
  logic        store_valid, store_ready;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_req, mem_ack, mem_err;
  logic        buffer_empty;
  logic [2:0]  buffer_count;
  logic        store_fault;
  logic [31:0] store_fault_addr;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } wr_t;

  wr_t         sbq[$];
  logic [31:0] fq[$];

  store_write_port #(.DEPTH(4), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .store_addr(store_addr), .store_val(store_val), .store_size(store_size),
    .store_valid(store_valid), .store_ready(store_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_req(mem_req), .mem_ack(mem_ack), .mem_err(mem_err),
    .buffer_empty(buffer_empty), .buffer_count(buffer_count),
    .store_fault(store_fault), .store_fault_addr(store_fault_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic wr_t model(input logic [31:0] a, input logic [31:0] v, input logic [1:0] sz);
    wr_t w;
    w.a = a & 32'hFFFF_FFFC;
    case (sz)
      2'b00: begin
        w.d = {v[7:0], v[7:0], v[7:0], v[7:0]};
        case (a[1:0])
          2'd0: w.s = 4'b0001;
          2'd1: w.s = 4'b0010;
          2'd2: w.s = 4'b0100;
          default: w.s = 4'b1000;
        endcase
      end
      2'b01: begin
        w.d = {v[15:0], v[15:0]};
        w.s = (a[1:0] == 2'd2) ? 4'b1100 : 4'b0011;
      end
      default: begin
        w.d = v;
        w.s = 4'b1111;
      end
    endcase
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] v, input logic [1:0] sz, input bit accept);
    store_addr  = a;
    store_val   = v;
    store_size  = sz;
    store_valid = 1'b1;
    if (sz == 2'b11)  fq.push_back(a);
    else if (accept)  sbq.push_back(model(a, v, sz));
    step();
    store_valid = 1'b0;
  endtask

  // Write monitor: a write completes at the next edge when req and ack are both high
  always @(negedge clk) begin
    if (reset_n && mem_req && mem_ack) begin
      if (sbq.size() == 0) begin
        check("unexpected_write", mem_addr, 32'hxxxx_xxxx);
      end else begin
        wr_t e;
        e = sbq.pop_front();
        check("wr_addr", mem_addr, e.a);
        check("wr_data", mem_wdata, e.d);
        check("wr_strb", {28'h0, mem_wstrb}, {28'h0, e.s});
      end
    end
  end

  // Fault monitor: every fault pulse must match a queued expected address
  always @(negedge clk) begin
    if (reset_n && store_fault) begin
      if (fq.size() == 0) check("unexpected_fault", store_fault_addr, 32'hxxxx_xxxx);
      else                check("fault_addr_sb", store_fault_addr, fq.pop_front());
    end
  end

  initial begin
    reset_n = 1'b0; store_addr = '0; store_val = '0; store_size = '0;
    store_valid = 1'b0; mem_ack = 1'b0; mem_err = 1'b0;
    #12;
    check("rst_ready", {31'h0, store_ready}, 32'd1);
    check("rst_empty", {31'h0, buffer_empty}, 32'd1);
    check("rst_count", {29'h0, buffer_count}, 32'd0);
    check("rst_req", {31'h0, mem_req}, 32'd0);
    check("rst_fault", {31'h0, store_fault}, 32'd0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_wdata", mem_wdata, 32'h0);
    check("rst_wstrb", {28'h0, mem_wstrb}, 32'h0);
    check("rst_faddr", store_fault_addr, 32'h0);
    reset_n = 1'b1;
    step();

    // Byte store, acked immediately; mem_req appears two edges after the push
    mem_ack = 1'b1;
    drive(32'h1003, 32'hAB, 2'b00, 1'b1);
    check("t1_req_early", {31'h0, mem_req}, 32'd0);
    check("t1_count", {29'h0, buffer_count}, 32'd1);
    step();
    check("t1_req", {31'h0, mem_req}, 32'd1);
    check("t1_addr", mem_addr, 32'h1000);
    check("t1_wstrb", {28'h0, mem_wstrb}, 32'h8);
    check("t1_wdata", mem_wdata, 32'hABAB_ABAB);
    step();
    check("t1_empty", {31'h0, buffer_empty}, 32'd1);
    check("t1_req_done", {31'h0, mem_req}, 32'd0);

    // Half then word with ack held: two consecutive request cycles
    drive(32'h2002, 32'h1234, 2'b01, 1'b1);
    drive(32'h3000, 32'hDEAD_BEEF, 2'b10, 1'b1);
    check("t2_req0", {31'h0, mem_req}, 32'd1);
    check("t2_wstrb0", {28'h0, mem_wstrb}, 32'hC);
    step();
    check("t2_req1", {31'h0, mem_req}, 32'd1);
    check("t2_wstrb1", {28'h0, mem_wstrb}, 32'hF);
    step();
    check("t2_req_end", {31'h0, mem_req}, 32'd0);
    mem_ack = 1'b0;

    // Fill the buffer with ack held low; a fifth push is refused
    for (int i = 0; i < 4; i++) drive(32'h7000 + 32'(4*i), 32'h100 + 32'(i), 2'b10, 1'b1);
    check("t3_ready_full", {31'h0, store_ready}, 32'd0);
    check("t3_count_full", {29'h0, buffer_count}, 32'd4);
    drive(32'h7010, 32'h999, 2'b10, 1'b0);
    check("t3_count_reject", {29'h0, buffer_count}, 32'd4);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check("t3_count_pop", {29'h0, buffer_count}, 32'd3);
    check("t3_ready_back", {31'h0, store_ready}, 32'd1);
    mem_ack = 1'b1;
    repeat (3) step();
    mem_ack = 1'b0;
    check("t3_drained", {31'h0, buffer_empty}, 32'd1);

    // Bus error on a word write
    drive(32'h4000, 32'h11, 2'b10, 1'b1);
    fq.push_back(32'h4000);
    mem_ack = 1'b1; mem_err = 1'b1;
    step();
    step();
    mem_ack = 1'b0; mem_err = 1'b0;
    check("t4_fault", {31'h0, store_fault}, 32'd1);
    check("t4_faddr", store_fault_addr, 32'h4000);
    step();
    check("t4_fault_pulse", {31'h0, store_fault}, 32'd0);
    check("t4_empty", {31'h0, buffer_empty}, 32'd1);

    // Reserved size is dropped and faults
    drive(32'h5000, 32'h22, 2'b11, 1'b0);
    check("t5_fault", {31'h0, store_fault}, 32'd1);
    check("t5_faddr", store_fault_addr, 32'h5000);
    check("t5_count", {29'h0, buffer_count}, 32'd0);
    step();
    check("t5_noreq", {31'h0, mem_req}, 32'd0);

    // Asynchronous reset during a pending request
    drive(32'h8000, 32'h33, 2'b10, 1'b1);
    step();
    check("t6_req", {31'h0, mem_req}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("t6_req_rst", {31'h0, mem_req}, 32'd0);
    check("t6_count_rst", {29'h0, buffer_count}, 32'd0);
    sbq.delete();
    step();
    reset_n = 1'b1;
    step();

`ifdef STORE_TIMEOUT_EN
    // Never-acked write is abandoned after eight request cycles
    fq.push_back(32'h6000);
    store_addr = 32'h6000; store_val = 32'h44; store_size = 2'b10; store_valid = 1'b1;
    step();
    store_valid = 1'b0;
    repeat (8) step();
    check("t7_fault_early", {31'h0, store_fault}, 32'd0);
    check("t7_req_wait", {31'h0, mem_req}, 32'd1);
    step();
    check("t7_fault", {31'h0, store_fault}, 32'd1);
    check("t7_faddr", store_fault_addr, 32'h6000);
    check("t7_count", {29'h0, buffer_count}, 32'd0);
    check("t7_req_drop", {31'h0, mem_req}, 32'd0);
    step();
`endif

    step();
    check("sb_writes_left", 32'(sbq.size()), 32'd0);
    check("sb_faults_left", 32'(fq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
